fifo_rr_arbiter: RTL and testbench

Round-robin controller that drains four input FIFOs into one shared output FIFO. It also owns the almost-full/almost-empty thresholds (umbral A/B) that configure those FIFOs. Per cycle it pops at most one non-empty input and pushes the word into the output FIFO one cycle later. It honours the output FIFO's pause flag and stops on any input FIFO error.

---
 rtl/fifo_rr_arbiter.sv | 82 ++++++++
 tb/tb_fifo_rr_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin drain of four input FIFOs into one output FIFO, plus threshold configuration
module fifo_rr_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int UMBRAL_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic [UMBRAL_WIDTH-1:0]   umbral_a_in,
  input  logic [UMBRAL_WIDTH-1:0]   umbral_b_in,
  input  logic [3:0]                in_empty,
  input  logic [3:0]                in_error,
  input  logic [4*DATA_WIDTH-1:0]   in_data,
  input  logic                      out_pause,
  output logic [3:0]                in_pop,
  output logic                      out_push,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [UMBRAL_WIDTH-1:0]   umbral_a,
  output logic [UMBRAL_WIDTH-1:0]   umbral_b,
  output logic [2:0]                state,
  output logic                      idle,
  output logic                      error_out,
  output logic [7:0]                words_out
);
  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;
  state_t                  state_q;
  logic [1:0]              ptr_q, lane_q, sel;
  logic                    push_q, pop;
  logic [UMBRAL_WIDTH-1:0] umbral_a_q, umbral_b_q;
  logic [7:0]              words_q;
  // descending scan so the nearest non-empty lane after ptr wins
  always_comb begin
    sel = ptr_q;
    for (int k = 4; k >= 1; k--)
      if (!in_empty[ptr_q + 2'(k)]) sel = ptr_q + 2'(k);
  end
  assign pop       = (state_q == S_ACTIVE) && !out_pause && !(|in_error) && !(&in_empty);
  assign in_pop    = pop ? 4'(4'b0001 << sel) : 4'b0000;
  assign out_push  = push_q;
  assign out_data  = push_q ? in_data[lane_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign umbral_a  = umbral_a_q;
  assign umbral_b  = umbral_b_q;
  assign state     = state_q;
  assign idle      = state_q == S_IDLE;
  assign error_out = state_q == S_ERROR;
  assign words_out = words_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RESET;
      ptr_q      <= 2'd3;
      lane_q     <= 2'd0;
      push_q     <= 1'b0;
      umbral_a_q <= UMBRAL_WIDTH'(6);
      umbral_b_q <= UMBRAL_WIDTH'(3);
      words_q    <= 8'd0;
    end else begin
      push_q  <= pop;
      words_q <= words_q + 8'(push_q);
      if (pop) begin
        ptr_q  <= sel;
        lane_q <= sel;
      end
      case (state_q)
        S_RESET:  state_q <= S_INIT;
        S_INIT:
          if (init) begin
            umbral_a_q <= umbral_a_in;
            umbral_b_q <= umbral_b_in;
          end else state_q <= S_IDLE;
        S_IDLE:   state_q <= |in_error ? S_ERROR : init ? S_INIT : !(&in_empty) ? S_ACTIVE : S_IDLE;
        S_ACTIVE: state_q <= |in_error ? S_ERROR : &in_empty ? S_IDLE : S_ACTIVE;
        default:  state_q <= S_ERROR;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: randomized scoreboard bench with queue-based input FIFOs and a spec-level reference model
module tb_fifo_rr_arbiter;
  logic        clk = 0, reset = 1, init = 0, out_pause = 0;
  logic [3:0]  umbral_a_in = 0, umbral_b_in = 0, in_empty = 4'hf, in_error = 0;
  logic [31:0] in_data = 0;
  logic [3:0]  in_pop, umbral_a, umbral_b;
  logic        out_push, idle, error_out;
  logic [7:0]  out_data, words_out;
  logic [2:0]  state;

  fifo_rr_arbiter dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_a_in(umbral_a_in), .umbral_b_in(umbral_b_in),
    .in_empty(in_empty), .in_error(in_error), .in_data(in_data),
    .out_pause(out_pause), .in_pop(in_pop), .out_push(out_push),
    .out_data(out_data), .umbral_a(umbral_a), .umbral_b(umbral_b),
    .state(state), .idle(idle), .error_out(error_out), .words_out(words_out)
  );

  always #5 clk = ~clk;

  logic [7:0] q [4][$];
  logic [7:0] dreg [4];
  logic [7:0] sb [$];
  int total = 0, passed = 0;

  int         m_state = 0, m_last = 3, m_lane = -1;
  logic [3:0] m_ua = 4'h6, m_ub = 4'h3;
  logic [7:0] m_words = 0;
  bit         m_pend = 0;

  function automatic void chk(string n, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
  endfunction

  always @(negedge clk) begin
    if (out_push === 1'b1) begin
      chk("push_has_expected_word", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) chk("out_data", 32'(out_data), 32'(sb.pop_front()));
    end
  end

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      in_empty[i] = q[i].size() == 0;
      in_data[i*8 +: 8] = dreg[i];
    end
  endtask

  task automatic cyc();
    logic [3:0] exp_pop;
    drive();
    @(negedge clk);
    m_lane = -1;
    if (m_state == 3 && !out_pause && in_error == 0)
      for (int k = 1; k <= 4; k++)
        if (m_lane < 0 && !in_empty[(m_last + k) % 4]) m_lane = (m_last + k) % 4;
    exp_pop = m_lane < 0 ? 4'b0 : 4'(1 << m_lane);
    chk("in_pop", 32'(in_pop), 32'(exp_pop));
    chk("state", 32'(state), 32'(m_state));
    chk("idle", 32'(idle), 32'(m_state == 2));
    chk("error_out", 32'(error_out), 32'(m_state == 4));
    chk("umbral_a", 32'(umbral_a), 32'(m_ua));
    chk("umbral_b", 32'(umbral_b), 32'(m_ub));
    chk("words_out", 32'(words_out), 32'(m_words));
    chk("out_push", 32'(out_push), 32'(m_pend));
    if (m_lane >= 0 && !reset) sb.push_back(q[m_lane][0]);
    @(posedge clk);
    #1;
    if (reset) begin
      m_state = 0; m_last = 3; m_ua = 4'h6; m_ub = 4'h3; m_words = 0; m_pend = 0;
    end else begin
      if (m_pend) m_words++;
      m_pend = m_lane >= 0;
      if (m_lane >= 0) m_last = m_lane;
      case (m_state)
        0: m_state = 1;
        1: if (init) begin m_ua = umbral_a_in; m_ub = umbral_b_in; end else m_state = 2;
        2: m_state = in_error != 0 ? 4 : init ? 1 : in_empty != 4'hf ? 3 : 2;
        3: m_state = in_error != 0 ? 4 : in_empty == 4'hf ? 2 : 3;
        default: m_state = 4;
      endcase
    end
    if (m_lane >= 0) dreg[m_lane] = q[m_lane].pop_front();
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic drain();
    int n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size() > 0 || m_pend) && n < 600) begin
      cyc();
      n++;
    end
    chk("drain_within_budget", 32'(n < 600), 1);
    run(2);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) dreg[i] = 0;
    @(posedge clk);
    #1;
    run(2);
    reset = 0;
    run(3);
    chk("idle_after_reset", 32'(state), 2);
    init = 1; umbral_a_in = 4'h5; umbral_b_in = 4'h2;
    cyc();
    cyc();
    init = 0;
    cyc();
    chk("umbral_a_cfg", 32'(umbral_a), 5);
    chk("umbral_b_cfg", 32'(umbral_b), 2);
    cyc();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++) q[i].push_back(8'(8'h10 + i));
    drain();
    for (int i = 0; i < 4; i++) q[2].push_back(8'(8'ha0 + i));
    run(2);
    out_pause = 1;
    run(3);
    out_pause = 0;
    drain();
    repeat (400) begin
      if ($urandom % 2 == 1) begin
        int l = $urandom % 4;
        if (q[l].size() < 5) q[l].push_back(8'($urandom));
      end
      out_pause   = $urandom % 4 == 0;
      init        = $urandom % 16 == 0;
      umbral_a_in = 4'($urandom);
      umbral_b_in = 4'($urandom);
      cyc();
    end
    out_pause = 0;
    init = 0;
    drain();
    for (int i = 0; i < 4; i++) begin
      q[0].push_back(8'($urandom));
      q[1].push_back(8'($urandom));
      q[3].push_back(8'($urandom));
    end
    run(4);
    in_error = 4'b0010;
    cyc();
    in_error = 4'b0000;
    run(3);
    chk("error_sticky", 32'(error_out), 1);
    reset = 1;
    cyc();
    reset = 0;
    chk("state_after_error_reset", 32'(state), 0);
    chk("umbral_a_default", 32'(umbral_a), 6);
    drain();
    for (int i = 0; i < 40; i++) q[0].push_back(8'(i));
    run(20);
    reset = 1;
    cyc();
    reset = 0;
    chk("words_cleared", 32'(words_out), 0);
    q[0].delete();
    for (int i = 0; i < 256; i++) q[0].push_back(8'($urandom));
    drain();
    chk("words_wrap", 32'(words_out), 0);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
